// File: rtl/sram_word_controller.sv
// Splits one WORD_W-bit pipeline read/write into BEATS accesses of an asynchronous
// SRAM_DQ_W-bit SRAM, each beat stretched by WAIT_CYCLES, then pulses ready for one cycle.
module sram_word_controller #(
    parameter int WORD_W      = 32,
    parameter int SRAM_DQ_W   = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [WORD_W-1:0]      writeData,
    output logic [WORD_W-1:0]      readData,
    output logic                   ready,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int BEATS    = WORD_W / SRAM_DQ_W;
    localparam int BB       = $clog2(BEATS);
    localparam int BW       = (BB > 0) ? BB : 1;
    localparam int ADDR_LSB = $clog2(WORD_W / 8);
    localparam int WW       = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q;
    logic [WW-1:0]         wait_q;
    logic                  op_write_q;
    logic [31:0]           addr_q;
    logic [WORD_W-1:0]     wdata_q;
    logic                  wait_done;
    logic                  last_beat;
    logic                  dq_oe;
    logic [SRAM_DQ_W-1:0]  dq_out;

    assign wait_done = (wait_q == WW'(WAIT_CYCLES));
    assign last_beat = (beat_q == BW'(BEATS - 1));

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en || rd_en) state_d = ACCESS;
            end
            ACCESS: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = op_write_q;
                SRAM_WE_N = !(op_write_q && !wait_done);
                dq_oe     = op_write_q;
                if (wait_done && last_beat) state_d = DONE;
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            wait_q     <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            readData   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        op_write_q <= wr_en;
                        addr_q     <= address;
                        wdata_q    <= writeData;
                        beat_q     <= '0;
                        wait_q     <= '0;
                    end
                end
                ACCESS: begin
                    if (!wait_done) begin
                        wait_q <= wait_q + WW'(1);
                    end else begin
                        wait_q <= '0;
                        if (!last_beat) beat_q <= beat_q + BW'(1);
                    end
                    // Read data has settled by the last wait cycle of the beat.
                    if (wait_done && !op_write_q) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (beat_q == BW'(i))
                                readData[WORD_W-1-i*SRAM_DQ_W -: SRAM_DQ_W] <= SRAM_DQ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat 0 carries the most-significant slice of the word.
    always_comb begin
        dq_out = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_q == BW'(i)) dq_out = wdata_q[WORD_W-1-i*SRAM_DQ_W -: SRAM_DQ_W];
        end
    end

    assign SRAM_ADDR = SRAM_ADDR_W'((addr_q >> ADDR_LSB) << BB) | SRAM_ADDR_W'(beat_q);
    assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DQ_W{1'bz}};
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_word_controller.sv
// Bench for sram_word_controller: a default 32-bit instance and a 64-bit/3-wait instance,
// each on its own SRAM model, checked cycle by cycle against arithmetic expectations.
module tb_sram_word_controller;

    localparam logic [15:0] PARK = 16'hA5C3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        wr0, rd0, ready0, we0, oe0, ce0, ub0, lb0;
    logic [31:0] addr_in0, wdata0, rdata0;
    logic [17:0] sa0;
    wire  [15:0] dq0;

    logic        wr1, rd1, ready1, we1, oe1, ce1, ub1, lb1;
    logic [31:0] addr_in1;
    logic [63:0] wdata1, rdata1;
    logic [17:0] sa1;
    wire  [15:0] dq1;

    sram_word_controller dut0 (
        .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(addr_in0),
        .writeData(wdata0), .readData(rdata0), .ready(ready0), .SRAM_DQ(dq0),
        .SRAM_ADDR(sa0), .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0),
        .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_word_controller #(.WORD_W(64), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr_in1),
        .writeData(wdata1), .readData(rdata1), .ready(ready1), .SRAM_DQ(dq1),
        .SRAM_ADDR(sa1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    // SRAM models: drive stored data on reads, a park pattern while deselected,
    // and leave the bus alone during controller write beats.
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];
    assign dq0 = ce0 ? PARK : (!oe0 ? mem0[sa0] : 16'hzzzz);
    assign dq1 = ce1 ? PARK : (!oe1 ? mem1[sa1] : 16'hzzzz);

    always @(posedge clk) begin
        if (!ce0 && !we0) mem0[sa0] <= dq0;
        if (!ce1 && !we1) mem1[sa1] <= dq1;
    end

    int total = 0;
    int bad   = 0;
    logic [63:0] refm [int];
    logic [63:0] last_rd [2];

    typedef struct {
        int          inst;
        logic        wr;
        logic        rd;
        logic [31:0] a;
        logic [63:0] d;
        logic        drop;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int inst, input logic wr, input logic rd,
                         input logic [31:0] a, input logic [63:0] d);
        if (inst == 0) begin
            wr0 = wr; rd0 = rd; addr_in0 = a; wdata0 = d[31:0];
        end else begin
            wr1 = wr; rd1 = rd; addr_in1 = a; wdata1 = d;
        end
    endtask

    function automatic logic [63:0] pins(input int inst, input logic mask_addr);
        logic [17:0] a;
        logic [15:0] dq;
        logic r, c, w, o;
        if (inst == 0) begin
            a = sa0; dq = dq0; r = ready0; c = ce0; w = we0; o = oe0;
        end else begin
            a = sa1; dq = dq1; r = ready1; c = ce1; w = we1; o = oe1;
        end
        if (mask_addr) a = '0;
        return {26'd0, r, c, w, o, a, dq};
    endfunction

    function automatic logic [63:0] exp_pins(input logic r, input logic c, input logic w,
                                             input logic o, input logic [17:0] a,
                                             input logic [15:0] dq);
        return {26'd0, r, c, w, o, a, dq};
    endfunction

    function automatic int key_of(input int inst, input logic [31:0] a);
        int lsb = (inst != 0) ? 3 : 2;
        int bb  = (inst != 0) ? 2 : 1;
        return int'((a >> lsb) & ((32'd1 << (18 - bb)) - 1)) + (inst << 24);
    endfunction

    function automatic logic [63:0] lookup(input int k);
        return refm.exists(k) ? refm[k] : 64'd0;
    endfunction

    // Word-level model: memory of whole words and the last word read per instance.
    task automatic model_apply(input int inst, input logic wr, input logic rd,
                               input logic [31:0] a, input logic [63:0] d,
                               output logic [63:0] exp);
        int k = key_of(inst, a);
        if (wr) refm[k] = (inst != 0) ? d : {32'd0, d[31:0]};
        else if (rd) last_rd[inst] = lookup(k);
        exp = last_rd[inst];
    endtask

    task automatic run_req(input int inst, input logic wr, input logic rd, input logic [31:0] a,
                           input logic [63:0] d, input logic drop, output logic [63:0] rdat);
        int beats = (inst != 0) ? 4 : 2;
        int wc    = (inst != 0) ? 3 : 1;
        int lsb   = (inst != 0) ? 3 : 2;
        int bb    = (inst != 0) ? 2 : 1;
        int len   = beats * (wc + 1);
        int beat, ph;
        logic [63:0] rword, ea, s;
        rword = lookup(key_of(inst, a));
        rdat  = '0;
        drive(inst, wr, rd, a, d);
        check($sformatf("inst%0d accept-cycle idle", inst), pins(inst, 1'b1),
              exp_pins(1'b0, 1'b1, 1'b1, 1'b1, 18'd0, PARK));
        for (int k = 1; k <= len + 1; k++) begin
            tick();
            if (k <= len) begin
                beat = (k - 1) / (wc + 1);
                ph   = (k - 1) % (wc + 1);
                ea   = ((64'(a) >> lsb) << bb) | 64'(beat);
                s    = (wr ? d : rword) >> (16 * (beats - 1 - beat));
                check($sformatf("inst%0d a=%h k=%0d beat pins", inst, a, k), pins(inst, 1'b0),
                      exp_pins(1'b0, 1'b0, !(wr && ph < wc), wr, ea[17:0], s[15:0]));
            end else begin
                check($sformatf("inst%0d a=%h done pins", inst, a), pins(inst, 1'b1),
                      exp_pins(1'b1, 1'b1, 1'b1, 1'b1, 18'd0, PARK));
                rdat = (inst != 0) ? rdata1 : {32'd0, rdata0};
                drive(inst, 1'b0, 1'b0, a, d);
            end
            if (drop && k == 1) drive(inst, 1'b0, 1'b0, a, d);
            if (drop && k == 2) drive(inst, 1'b0, 1'b0, a ^ 32'h0000_0FF0, ~d);
        end
        tick();
        check($sformatf("inst%0d post-done idle", inst), pins(inst, 1'b1),
              exp_pins(1'b0, 1'b1, 1'b1, 1'b1, 18'd0, PARK));
    endtask

    initial begin
        logic [63:0] got, exp;
        logic [63:0] rpat;
        for (int i = 0; i < 262144; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        last_rd[0] = '0;
        last_rd[1] = '0;

        tbl[0]  = '{0, 1'b1, 1'b0, 32'h0000_0104, 64'hDEADBEEF,         1'b0, 64'h0};
        tbl[1]  = '{0, 1'b0, 1'b1, 32'h0000_0104, 64'h0,                1'b0, 64'hDEADBEEF};
        tbl[2]  = '{0, 1'b1, 1'b0, 32'h0000_0108, 64'hCAFEF00D,         1'b0, 64'hDEADBEEF};
        tbl[3]  = '{0, 1'b1, 1'b1, 32'h0000_0008, 64'h11112222,         1'b0, 64'hDEADBEEF};
        tbl[4]  = '{0, 1'b0, 1'b1, 32'h0000_0008, 64'h0,                1'b0, 64'h11112222};
        tbl[5]  = '{0, 1'b1, 1'b0, 32'h0000_010C, 64'h13572468,         1'b1, 64'h11112222};
        tbl[6]  = '{0, 1'b0, 1'b1, 32'h0000_010C, 64'h0,                1'b0, 64'h13572468};
        tbl[7]  = '{1, 1'b1, 1'b0, 32'h0000_0040, 64'h0123456789ABCDEF, 1'b0, 64'h0};
        tbl[8]  = '{1, 1'b0, 1'b1, 32'h0000_0040, 64'h0,                1'b0, 64'h0123456789ABCDEF};
        tbl[9]  = '{0, 1'b0, 1'b1, 32'h0008_0104, 64'h0,                1'b0, 64'hDEADBEEF};
        tbl[10] = '{0, 1'b1, 1'b0, 32'h0007_FFFC, 64'hA5A55A5A,         1'b0, 64'hDEADBEEF};
        tbl[11] = '{0, 1'b0, 1'b1, 32'h0007_FFFC, 64'h0,                1'b0, 64'hA5A55A5A};
        tbl[12] = '{0, 1'b0, 1'b1, 32'h0000_0108, 64'h0,                1'b1, 64'hCAFEF00D};

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 64'd0);
        repeat (3) tick();
        check("reset pins inst0", pins(0, 1'b0), exp_pins(1'b0, 1'b1, 1'b1, 1'b1, 18'd0, PARK));
        check("reset pins inst1", pins(1, 1'b0), exp_pins(1'b0, 1'b1, 1'b1, 1'b1, 18'd0, PARK));
        check("reset readData inst0", {32'd0, rdata0}, 64'd0);
        check("reset readData inst1", rdata1, 64'd0);
        check("byte lanes tied low", {60'd0, ub0, lb0, ub1, lb1}, 64'd0);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            run_req(tbl[i].inst, tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].drop, got);
            model_apply(tbl[i].inst, tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, exp);
            check($sformatf("table %0d readData", i), got, tbl[i].exp);
        end

        // Read held across DONE: re-accepted in the following idle cycle.
        rpat = '0;
        drive(0, 1'b0, 1'b1, 32'h0000_0104, 64'd0);
        for (int k = 0; k < 12; k++) begin
            rpat[k] = ready0;
            if (k == 11) begin
                check("back-to-back readData", {32'd0, rdata0}, 64'hDEADBEEF);
                drive(0, 1'b0, 1'b0, 32'h0000_0104, 64'd0);
            end
            tick();
        end
        check("back-to-back ready cycles", rpat, 64'h820);

        // Reset in cycle T+3 of a write aborts without a ready pulse.
        drive(0, 1'b1, 1'b0, 32'h0000_0200, 64'h55AA33CC);
        repeat (3) tick();
        check("abort still in access", {63'd0, ce0}, 64'd0);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0000_0200, 64'd0);
        tick();
        check("abort pins after reset", pins(0, 1'b0),
              exp_pins(1'b0, 1'b1, 1'b1, 1'b1, 18'd0, PARK));
        check("abort readData cleared", {32'd0, rdata0}, 64'd0);
        last_rd[0] = '0;
        rst = 1'b0;
        tick();
        check("abort no ready pulse", pins(0, 1'b1),
              exp_pins(1'b0, 1'b1, 1'b1, 1'b1, 18'd0, PARK));
        run_req(0, 1'b0, 1'b1, 32'h0000_0104, 64'd0, 1'b0, got);
        model_apply(0, 1'b0, 1'b1, 32'h0000_0104, 64'd0, exp);
        check("read after abort", got, exp);

        for (int i = 0; i < 40; i++) begin
            int inst;
            int op;
            logic [31:0] a;
            logic [63:0] d;
            logic drop;
            inst = int'($urandom_range(0, 1));
            op   = int'($urandom_range(0, 2));
            if (inst == 0) begin
                a = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
                d = {32'd0, $urandom};
            end else begin
                a = ($urandom_range(0, 15) << 3) | $urandom_range(0, 7);
                d = {$urandom, $urandom};
            end
            a    = a | ($urandom & 32'hFFF0_0000);
            drop = ($urandom_range(0, 3) == 0);
            run_req(inst, op != 1, op != 0, a, d, drop, got);
            model_apply(inst, op != 1, op != 0, a, d, exp);
            check($sformatf("random %0d inst%0d op%0d readData", i, inst, op), got, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
